// File: rtl/exec_unit_p.sv
// exec_unit_p -- single-issue execute unit with NZCV flags and optional
// iterative multiplier.
//
// Optional feature: define EXEC_UNIT_MUL_EN to build the shift-add multiplier
// (op 5). Without it, op 5 behaves like reserved op 7 and busy stays 0.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   op, use_imm, set_flags, src_a, src_b, imm, dest, cond   request fields
//   out_valid/out_ready result handshake
//   out_data, out_dest, out_wr, br_taken   registered result
//   flags               NZCV register {N,Z,C,V}
//   busy                multiplier in progress
module exec_unit_p #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic              use_imm,
  input  logic              set_flags,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [IMM_W-1:0]  imm,
  input  logic [3:0]        dest,
  input  logic [3:0]        cond,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_dest,
  output logic              out_wr,
  output logic              br_taken,
  output logic [3:0]        flags,
  output logic              busy
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_MOV = 3'd3;
  localparam logic [2:0] OP_CLR = 3'd4;
  localparam logic [2:0] OP_BR  = 3'd6;

  logic              accept, accept_alu;
  logic [DATA_W-1:0] opb, res;
  logic [DATA_W:0]   sum, dif;
  logic              c_n, v_n, wr_n, br_n, upd;

  assign accept = in_valid && in_ready;
  assign opb    = use_imm ? DATA_W'($signed(imm)) : src_b;
  assign sum    = {1'b0, src_a} + {1'b0, opb};
  assign dif    = {1'b0, src_a} - {1'b0, opb};

  // Single-cycle ALU result and flag candidates.
  always_comb begin
    res  = '0;
    c_n  = flags[1];
    v_n  = flags[0];
    wr_n = 1'b1;
    br_n = 1'b0;
    upd  = set_flags;
    case (op)
      OP_ADD: begin
        res = sum[DATA_W-1:0];
        c_n = sum[DATA_W];
        v_n = (src_a[DATA_W-1] == opb[DATA_W-1]) && (res[DATA_W-1] != src_a[DATA_W-1]);
      end
      OP_SUB: begin
        res = dif[DATA_W-1:0];
        c_n = ~dif[DATA_W];  // carry = not borrow
        v_n = (src_a[DATA_W-1] != opb[DATA_W-1]) && (res[DATA_W-1] != src_a[DATA_W-1]);
      end
      OP_NOT: res = ~src_a;
      OP_MOV: res = opb;
      OP_CLR: res = '0;
      OP_BR: begin
        wr_n = 1'b0;
        upd  = 1'b0;
        case (cond)
          4'd0:    br_n = flags[2];
          4'd1:    br_n = ~flags[2];
          4'd4:    br_n = flags[3];
          4'd5:    br_n = ~flags[3];
          4'd14:   br_n = 1'b1;
          default: br_n = 1'b0;
        endcase
      end
      default: begin  // reserved (and op 5 when the multiplier is absent)
        wr_n = 1'b0;
        upd  = 1'b0;
      end
    endcase
  end

`ifdef EXEC_UNIT_MUL_EN
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam int         CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t            state;
  logic [DATA_W-1:0] mcand, mplier, acc, acc_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        mul_dest;
  logic              mul_sf;

  assign acc_nxt    = acc + (mplier[0] ? mcand : '0);
  assign accept_alu = accept && (op != OP_MUL);
  assign busy       = (state != S_IDLE);
  assign in_ready   = (state == S_IDLE) && (!out_valid || out_ready);
`else
  assign accept_alu = accept;
  assign busy       = 1'b0;
  assign in_ready   = !out_valid || out_ready;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dest  <= '0;
      out_wr    <= 1'b0;
      br_taken  <= 1'b0;
      flags     <= '0;
`ifdef EXEC_UNIT_MUL_EN
      state     <= S_IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      mul_dest  <= '0;
      mul_sf    <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept_alu) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_dest  <= dest;
        out_wr    <= wr_n;
        br_taken  <= br_n;
        if (upd) flags <= {res[DATA_W-1], res == '0, c_n, v_n};
      end
`ifdef EXEC_UNIT_MUL_EN
      case (state)
        S_IDLE: if (accept && op == OP_MUL) begin
          state    <= S_MUL;
          mcand    <= src_a;
          mplier   <= opb;
          acc      <= '0;
          cnt      <= '0;
          mul_dest <= dest;
          mul_sf   <= set_flags;
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Last iteration folds directly into the output register.
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state     <= S_IDLE;
            out_valid <= 1'b1;
            out_data  <= acc_nxt;
            out_dest  <= mul_dest;
            out_wr    <= 1'b1;
            br_taken  <= 1'b0;
            if (mul_sf) flags <= {acc_nxt[DATA_W-1], acc_nxt == '0, 2'b00};
          end
        end
        default: state <= S_IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_exec_unit_p.sv
module tb_exec_unit_p;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  op;
  logic        use_imm, set_flags;
  logic [31:0] src_a, src_b;
  logic [15:0] imm;
  logic [3:0]  dest, cond;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_dest;
  logic        out_wr, br_taken;
  logic [3:0]  flags;
  logic        busy;

  exec_unit_p #(.DATA_W(32), .IMM_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .use_imm(use_imm), .set_flags(set_flags), .src_a(src_a), .src_b(src_b),
    .imm(imm), .dest(dest), .cond(cond), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
    .out_wr(out_wr), .br_taken(br_taken), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [3:0]  dest;
    logic        wr;
    logic        br;
    logic [3:0]  flags;
  } exp_t;

  exp_t        sbq[$];
  logic [3:0]  m_flags;
  int unsigned n_cmp = 0, n_bad = 0;
  logic        acc_pend = 1'b0, lat1 = 1'b0, lat1_op = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: computes the expected result and advances model flags.
  task automatic model_push(input logic [2:0] o, input logic ui, input logic sf,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [15:0] im, input logic [3:0] cd, input logic [3:0] ds);
    exp_t        e;
    logic [31:0] ob, r;
    logic        c, v, wf;
    longint      s;
    ob = ui ? {{16{im[15]}}, im} : b;
    r = 32'h0; c = m_flags[1]; v = m_flags[0]; wf = sf;
    e.dest = ds; e.wr = 1'b1; e.br = 1'b0; e.chk_data = 1'b1;
    case (o)
      3'd0: begin
        s = longint'(a) + longint'(ob);
        r = s[31:0]; c = s[32];
        v = (a[31] == ob[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        r = a - ob; c = (a >= ob);
        v = (a[31] != ob[31]) && (r[31] != a[31]);
      end
      3'd2: r = ~a;
      3'd3: r = ob;
      3'd4: r = 32'h0;
`ifdef EXEC_UNIT_MUL_EN
      3'd5: begin r = a * ob; c = 1'b0; v = 1'b0; end
`endif
      3'd6: begin
        wf = 1'b0; e.wr = 1'b0;
        case (cd)
          4'd0:  e.br = m_flags[2];
          4'd1:  e.br = !m_flags[2];
          4'd4:  e.br = m_flags[3];
          4'd5:  e.br = !m_flags[3];
          4'd14: e.br = 1'b1;
          default: e.br = 1'b0;
        endcase
      end
      default: begin wf = 1'b0; e.wr = 1'b0; e.chk_data = 1'b0; end
    endcase
    if (wf) m_flags = {r[31], r == 32'h0, c, v};
    e.data = r;
    e.flags = m_flags;
    sbq.push_back(e);
  endtask

  // One clock: checks at negedge, returns at posedge+1.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (lat1) begin chk("latency1_valid", out_valid, 1); lat1 = 1'b0; end
    if (out_valid && out_ready) begin
      chk("sb_has_entry", 64'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        if (e.chk_data) chk("out_data", out_data, e.data);
        chk("out_dest", out_dest, e.dest);
        chk("out_wr", out_wr, e.wr);
        chk("br_taken", br_taken, e.br);
        chk("flags", flags, e.flags);
      end
    end
    if (acc_pend) begin chk("in_ready_on_issue", in_ready, 1); acc_pend = 1'b0; lat1 = lat1_op; end
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic ui, input logic sf,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                       input logic [3:0] cd, input logic [3:0] ds, input logic push);
    in_valid = 1'b1; op = o; use_imm = ui; set_flags = sf;
    src_a = a; src_b = b; imm = im; cond = cd; dest = ds;
    acc_pend = 1'b1;
`ifdef EXEC_UNIT_MUL_EN
    lat1_op = (o != 3'd5);
`else
    lat1_op = 1'b1;
`endif
    if (push) model_push(o, ui, sf, a, b, im, cd, ds);
    cyc();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; op = 3'd0; use_imm = 1'b0; set_flags = 1'b0;
    src_a = 0; src_b = 0; imm = 0; dest = 0; cond = 0; out_ready = 1'b1;
    m_flags = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_dest", out_dest, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_flags", flags, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;

    // Back-to-back stream, first accept on the first edge after reset release.
    issue(3'd0, 0, 1, 32'd5, 32'd7, 16'h0, 4'd0, 4'd3, 1);
    issue(3'd1, 1, 1, 32'd3, 32'd99, 16'd3, 4'd0, 4'd4, 1);
    issue(3'd6, 0, 0, 32'd0, 32'd0, 16'h0, 4'd0, 4'd5, 1);
    issue(3'd0, 0, 1, 32'h7FFF_FFFF, 32'd1, 16'h0, 4'd0, 4'd6, 1);
    issue(3'd6, 0, 0, 32'd0, 32'd0, 16'h0, 4'd4, 4'd0, 1);
    issue(3'd6, 0, 0, 32'd0, 32'd0, 16'h0, 4'd1, 4'd0, 1);
    issue(3'd6, 0, 0, 32'd0, 32'd0, 16'h0, 4'd2, 4'd0, 1);
    issue(3'd6, 0, 0, 32'd0, 32'd0, 16'h0, 4'd14, 4'd0, 1);
    issue(3'd1, 0, 1, 32'd3, 32'd5, 16'h0, 4'd0, 4'd7, 1);
    issue(3'd1, 0, 1, 32'h8000_0000, 32'd1, 16'h0, 4'd0, 4'd8, 1);
    issue(3'd2, 0, 1, 32'h0F0F_0F0F, 32'd0, 16'h0, 4'd0, 4'd9, 1);
    issue(3'd3, 1, 1, 32'd0, 32'd0, 16'hFFF0, 4'd0, 4'd10, 1);
    issue(3'd4, 0, 1, 32'd0, 32'd0, 16'h0, 4'd0, 4'd11, 1);
    issue(3'd6, 0, 0, 32'd0, 32'd0, 16'h0, 4'd5, 4'd0, 1);
    issue(3'd0, 0, 0, 32'd1, 32'd2, 16'h0, 4'd0, 4'd12, 1);
    issue(3'd7, 0, 1, 32'd1, 32'd2, 16'h0, 4'd0, 4'd13, 1);
    idle();

    // Backpressure: result held, inputs ignored while stalled.
    out_ready = 1'b0;
    issue(3'd0, 0, 0, 32'd100, 32'd23, 16'h0, 4'd0, 4'd14, 1);
    op = 3'd4; src_a = 32'hDEAD; dest = 4'd1;  // in_valid still high, must be ignored
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_out_data", out_data, 32'd123);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    idle();

`ifdef EXEC_UNIT_MUL_EN
    begin
      int nb, nc;
      logic seen;
      nb = 0; nc = 0;
      issue(3'd5, 0, 1, 32'd6, 32'd7, 16'h0, 4'd0, 4'd2, 1);
      in_valid = 1'b0;
      for (int i = 0; i < 40 && !out_valid; i++) begin
        if (busy) nb++;
        if (busy && in_ready) chk("mul_in_ready", in_ready, 0);
        cyc();
        nc++;
      end
      chk("mul_busy_cycles", nb, 32);
      chk("mul_latency", nc, 32);
      idle();
      // Reset in the middle of a multiply aborts it.
      issue(3'd5, 0, 1, 32'd9, 32'd9, 16'h0, 4'd0, 4'd2, 0);
      in_valid = 1'b0;
      repeat (9) cyc();
      rst = 1'b0; #1;
      m_flags = 4'h0;
      chk("midmul_rst_busy", busy, 0);
      chk("midmul_rst_valid", out_valid, 0);
      @(negedge clk); rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin cyc(); if (out_valid) seen = 1'b1; end
      chk("midmul_no_result", seen, 0);
    end
`else
    issue(3'd0, 0, 1, 32'd0, 32'd0, 16'h0, 4'd0, 4'd1, 1);  // flags -> 0100
    issue(3'd5, 0, 1, 32'd6, 32'd7, 16'h0, 4'd0, 4'd2, 1);
    chk("op5_busy", busy, 0);
    idle();
`endif
    idle();
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/exec_unit_p.md
EXEC_UNIT_P -- requirements
Module: exec_unit_p

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width (legal 8..64).
REQ-002 Parameter IMM_W, default 16, immediate width (legal 1..DATA_W).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit accepts request this cycle.
REQ-007 op  input  3  0 ADD, 1 SUB, 2 NOT, 3 MOV, 4 CLR, 5 MUL, 6 BR, 7 reserved.
REQ-008 use_imm  input  1  second operand is sign-extended imm instead of src_b.
REQ-009 set_flags  input  1  result updates NZCV.
REQ-010 src_a, src_b  input  DATA_W  operand values.
REQ-011 imm  input  IMM_W  signed immediate.
REQ-012 dest  input  4  destination register index.
REQ-013 cond  input  4  branch condition, BR only.
REQ-014 out_valid  output  1  result held.
REQ-015 out_ready  input  1  consumer takes result.
REQ-016 out_data  output  DATA_W  result.
REQ-017 out_dest  output  4  registered copy of dest.
REQ-018 out_wr  output  1  result writes register file.
REQ-019 br_taken  output  1  BR condition true.
REQ-020 flags  output  4  NZCV register, {N,Z,C,V}.
REQ-021 busy  output  1  FSM not IDLE.

Function
REQ-022 Transfer in when in_valid and in_ready; transfer out when out_valid and out_ready.
REQ-023 in_ready = (state==IDLE) and (!out_valid or out_ready); full throughput, one op per cycle, for non-MUL ops.
REQ-024 FSM states IDLE, MUL; IDLE->MUL on accepted MUL; MUL->IDLE after DATA_W iterations, loading the output register.
REQ-025 Non-MUL ops: result registered on accept edge; out_valid high the following cycle (latency 1).
REQ-026 MUL: shift-add, one multiplier bit per cycle, unsigned, low DATA_W bits returned; out_valid rises DATA_W+1 cycles after accept.
REQ-027 Operand B = use_imm ? sign-extended imm : src_b.
REQ-028 ADD/SUB computed at DATA_W+1 bits; C = carry (ADD) or NOT borrow (SUB); V = signed overflow.
REQ-029 NOT = ~src_a; MOV = operand B; CLR = 0; all have C, V unchanged when set_flags.
REQ-030 N = result MSB, Z = (result==0); flags written on the edge the result enters the output register, only if set_flags.
REQ-031 MUL with set_flags: N, Z from result; C=V=0.
REQ-032 BR: out_wr=0, out_data=0; br_taken from the flags register as of the accept edge: cond 0 Z, 1 !Z, 4 N, 5 !N, 14 always, others 0.
REQ-033 BR accepted the cycle after a flag-setting op sees the updated flags.
REQ-034 Output register holds while out_valid and !out_ready.
REQ-035 op 7: out_valid with out_wr=0, flags unchanged.
REQ-036 Input fields are ignored while in_ready=0.

Reset
REQ-037 On rst low: state=IDLE, out_valid=0, out_data=0, out_dest=0, out_wr=0, br_taken=0, flags=0, busy=0, multiplier state cleared.
REQ-038 Reset mid-MUL aborts the operation; no result is produced after release.
REQ-039 First accept is possible on the first rising edge after rst rises.

Configuration
REQ-040 Macro EXEC_UNIT_MUL_EN: defined, MUL behaves per REQ-024/026/031.
REQ-041 Macro EXEC_UNIT_MUL_EN undefined: no multiplier logic and no MUL state; op 5 is handled as op 7, latency 1, busy always 0.

Verification
REQ-042 Reset: ADD src_a=5, src_b=7, set_flags=1 -> next cycle out_data=12, out_wr=1, flags=0000.
REQ-043 SUB with use_imm, src_a=3, imm=3, set_flags=1 -> out_data=0, flags=0110; then BR cond=0 -> br_taken=1, out_wr=0.
REQ-044 ADD src_a=0x7FFFFFFF, src_b=1, set_flags=1, DATA_W=32 -> out_data=0x80000000, flags=1001.
REQ-045 MUL src_a=6, src_b=7 (MUL_EN) -> busy for 32 cycles, in_ready=0, out_data=42 on cycle 33; rst low at cycle 10 -> out_valid stays 0.
REQ-046 out_ready=0 for 3 cycles with result held -> out_data stable, in_ready=0; back-to-back ADDs with out_ready=1 -> one result per cycle.
REQ-047 MUL_EN undefined, op=5 -> out_valid next cycle, out_wr=0, flags unchanged.
